// File: rtl/apb_slave_responder.sv
// APB4 completer with programmable wait states and a word-addressed register memory.
// The SETUP phase is recognised in StIdle, so a transfer can complete in SETUP + 1 ACCESS cycle.
module apb_slave_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [3:0]              wait_cfg,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    output logic                    protocol_err,
    output logic [15:0]             xfer_count
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
    localparam int unsigned WordW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    write_q, err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [StrbW-1:0]        strb_q;
    logic [IdxW-1:0]         idx_q;
    logic                    pready_q, pslverr_q, protocol_err_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [15:0]             xfer_count_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [WordW-1:0]        word_off;
    logic [IdxW-1:0]         dec_idx;
    logic                    dec_err;
    logic                    latch_en, complete, use_live, perr_set, mismatch;
    logic                    c_write, c_err;
    logic [IdxW-1:0]         c_idx;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic [StrbW-1:0]        c_strb;

    always_comb begin
        word_off = paddr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
        dec_idx  = word_off[IdxW-1:0];
        dec_err  = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) || (|word_off[WordW-1:IdxW]);
        mismatch = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q) ||
                   (pstrb != strb_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        complete = 1'b0;
        use_live = 1'b0;
        perr_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (psel && !penable) begin
                    latch_en = 1'b1;
                    if (wait_cfg == 4'd0) begin
                        // Zero wait states: complete straight from the live SETUP values.
                        complete = 1'b1;
                        use_live = 1'b1;
                        state_d  = StDone;
                    end else begin
                        cnt_d   = wait_cfg - 4'd1;
                        state_d = StWait;
                    end
                end else if (psel && penable) begin
                    perr_set = 1'b1;
                end
            end
            StWait: begin
                if (!psel) begin
                    perr_set = 1'b1;
                    state_d  = StIdle;
                end else begin
                    perr_set = mismatch;
                    if (cnt_q == 4'd0) begin
                        complete = 1'b1;
                        state_d  = StDone;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StDone: begin
                perr_set = psel && mismatch;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        c_write = use_live ? pwrite  : write_q;
        c_err   = use_live ? dec_err : err_q;
        c_idx   = use_live ? dec_idx : idx_q;
        c_wdata = use_live ? pwdata  : wdata_q;
        c_strb  = use_live ? pstrb   : strb_q;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            write_q        <= 1'b0;
            err_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            strb_q         <= '0;
            idx_q          <= '0;
            pready_q       <= 1'b0;
            pslverr_q      <= 1'b0;
            prdata_q       <= '0;
            protocol_err_q <= 1'b0;
            xfer_count_q   <= '0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            protocol_err_q <= protocol_err_q | perr_set;
            pready_q       <= complete;
            pslverr_q      <= complete && c_err;
            prdata_q       <= '0;
            if (latch_en) begin
                write_q <= pwrite;
                err_q   <= dec_err;
                addr_q  <= paddr;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                idx_q   <= dec_idx;
            end
            if (complete) begin
                xfer_count_q <= xfer_count_q + 16'd1;
                if (!c_err && c_write) begin
                    for (int b = 0; b < int'(StrbW); b++) begin
                        if (c_strb[b]) mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                    end
                end else if (!c_err) begin
                    prdata_q <= mem_q[c_idx];
                end
            end
        end
    end

    assign pready       = pready_q;
    assign prdata       = prdata_q;
    assign pslverr      = pslverr_q;
    assign protocol_err = protocol_err_q;
    assign xfer_count   = xfer_count_q;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed bench for apb_slave_responder: a vector table of transfers plus hand-written
// sequences for protocol violations and reset in the middle of a transfer.
module tb_apb_slave_responder;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb, wait_cfg;
    logic        pready, pslverr, protocol_err;
    logic [31:0] prdata;
    logic [15:0] xfer_count;

    int n_pass  = 0;
    int n_total = 0;

    apb_slave_responder dut (
        .pclk         (pclk),
        .preset       (preset),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pstrb        (pstrb),
        .wait_cfg     (wait_cfg),
        .pready       (pready),
        .prdata       (prdata),
        .pslverr      (pslverr),
        .protocol_err (protocol_err),
        .xfer_count   (xfer_count)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  wcfg;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
    endtask

    task automatic setup_phase(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [3:0] wc);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        wait_cfg = wc;
        @(posedge pclk); #1;
        penable  = 1'b1;
        wait_cfg = ~wc;  // must not affect the transfer in flight
    endtask

    // Waits for pready (bounded); lat is the ACCESS cycle in which it was seen, 99 on timeout.
    task automatic wait_ready(output int lat, output logic [31:0] rd, output logic err);
        logic got = 1'b0;
        lat = 0; rd = 'x; err = 1'bx;
        while (!got && lat < 40) begin
            lat++;
            @(negedge pclk);
            if (pready) begin
                got = 1'b1; rd = prdata; err = pslverr;
            end
        end
        if (!got) lat = 99;
    endtask

    task automatic xfer(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [3:0] wc,
                        output logic [31:0] rd, output logic err, output int lat);
        setup_phase(w, a, d, s, wc);
        wait_ready(lat, rd, err);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check({name, "_post_zero"}, {pready, pslverr, prdata[29:0]}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        seen;

        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 4'd0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 4'd0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h00, 32'h0,        4'h0, 4'd3, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 4'd1, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 4'd2, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, 4'd0, 32'h11BB33DD, 1'b0};
        vecs[6]  = '{1'b0, 32'h40, 32'h0,        4'h0, 4'd0, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h02, 32'hCAFEF00D, 4'hF, 4'd0, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, 4'd0, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 32'h3C, 32'h12345678, 4'hF, 4'd5, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h3C, 32'h0,        4'h0, 4'd0, 32'h12345678, 1'b0};
        vecs[11] = '{1'b0, 32'h04, 32'h0,        4'h0, 4'd1, 32'hDEADBEEF, 1'b0};

        do_reset();
        @(negedge pclk);
        check("reset_outputs", {29'h0, pready, pslverr, protocol_err}, 32'h0);
        check("reset_prdata", prdata, 32'h0);
        check("reset_count", {16'h0, xfer_count}, 32'h0);

        foreach (vecs[i]) begin
            xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].wcfg, rd, err, lat);
            check($sformatf("v%0d_latency", i), lat, 32'(vecs[i].wcfg) + 1);
            check($sformatf("v%0d_pslverr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            if (!vecs[i].wr || vecs[i].exp_err)
                check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rdata);
        end
        check("count_after_table", {16'h0, xfer_count}, 32'd12);
        check("no_perr_after_table", {31'h0, protocol_err}, 32'h0);

        // Address and data change during ACCESS: flagged, latched values still used.
        setup_phase(1'b1, 32'h18, 32'h0BADF00D, 4'hF, 4'd1);
        paddr = 32'h1C; pwdata = 32'h1;
        wait_ready(lat, rd, err);
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
        check("mismatch_latency", lat, 32'd2);
        check("mismatch_perr", {31'h0, protocol_err}, 32'h1);
        xfer("mm_rd18", 1'b0, 32'h18, 32'h0, 4'h0, 4'd0, rd, err, lat);
        check("mismatch_latched_addr", rd, 32'h0BADF00D);
        xfer("mm_rd1c", 1'b0, 32'h1C, 32'h0, 4'h0, 4'd0, rd, err, lat);
        check("mismatch_other_word", rd, 32'h0);
        check("mismatch_count", {16'h0, xfer_count}, 32'd15);

        // psel with penable while idle.
        do_reset();
        @(negedge pclk);
        check("perr_cleared_by_reset", {31'h0, protocol_err}, 32'h0);
        seen = 1'b0;
        @(posedge pclk); #1; psel = 1'b1; penable = 1'b1;
        @(negedge pclk); seen |= pready;
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
        repeat (3) begin @(negedge pclk); seen |= pready; end
        check("idle_penable_perr", {31'h0, protocol_err}, 32'h1);
        check("idle_penable_no_ready", {31'h0, seen}, 32'h0);
        check("idle_penable_count", {16'h0, xfer_count}, 32'h0);

        // psel dropped during a wait state.
        xfer("ab_wr", 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 4'd0, rd, err, lat);
        seen = 1'b0;
        setup_phase(1'b1, 32'h10, 32'h5A5A5A5A, 4'hF, 4'd3);
        @(negedge pclk); seen |= pready;
        @(posedge pclk); #1; psel = 1'b0; penable = 1'b0;
        repeat (5) begin @(negedge pclk); seen |= pready; end
        check("abandon_no_ready", {31'h0, seen}, 32'h0);
        check("abandon_perr_sticky", {31'h0, protocol_err}, 32'h1);
        check("abandon_count", {16'h0, xfer_count}, 32'd1);
        xfer("ab_rd", 1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, lat);
        check("abandon_mem_kept", rd, 32'hA5A5A5A5);

        // Reset asserted in the 2nd wait state of a write.
        xfer("rst_rd", 1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, lat);
        setup_phase(1'b1, 32'h14, 32'hFEEDFACE, 4'hF, 4'd4);
        @(posedge pclk); #2;
        preset = 1'b1;
        #1;
        check("midreset_flags", {29'h0, pready, pslverr, protocol_err}, 32'h0);
        check("midreset_prdata", prdata, 32'h0);
        check("midreset_count", {16'h0, xfer_count}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1; preset = 1'b0;
        xfer("midreset_rd14", 1'b0, 32'h14, 32'h0, 4'h0, 4'd0, rd, err, lat);
        check("midreset_no_commit", rd, 32'h0);
        xfer("midreset_rd10", 1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, lat);
        check("midreset_mem_cleared", rd, 32'h0);
        check("midreset_count_after", {16'h0, xfer_count}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
